// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Turns a valid/ready command interface into single APB3 requester
//   transfers (SETUP -> ACCESS, with pready wait states). Each transfer ends
//   with a one-cycle response strobe carrying read data and an error flag.
//   Only one transfer is outstanding at any time.
//
// Optional feature:
//   APB_MASTER_TIMEOUT_EN - when defined, a transfer whose ACCESS phase sees
//   pready low for TIMEOUT_CYCLES cycles is aborted and answered with
//   rsp_err=1. When undefined, ACCESS waits on pready indefinitely.
//
// Ports:
//   pclk, presetn            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_write/addr/wdata     command payload
//   rsp_valid                one-cycle completion strobe
//   rsp_rdata, rsp_err       read data (0 on write/error), error flag
//   psel/penable/pwrite      APB control
//   paddr/pwdata             APB address / write data (held between transfers)
//   prdata/pready/pslverr    APB completer response
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter value seen in the last tolerated wait cycle; the edge that would
  // take the counter to TIMEOUT_CYCLES aborts the transfer instead.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state, APB control and response capture.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // cmd_ready is implied by ST_IDLE, so this is the acceptance edge.
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          // Normal completion takes priority over a coincident timeout.
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          if (!pwrite_q && !pslverr) begin
            rsp_rdata_d = prdata;
          end else begin
            rsp_rdata_d = {DATA_W{1'b0}};
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
          tmo_cnt_d   = tmo_cnt_q + 8'd1;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 8'd1;
        end
`else
        else begin
          state_d = ST_ACCESS;
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops psel/penable without a clock.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // ACCESS-phase wait-state counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge. A small 32-word APB RAM completer
// (addresses >= 32 answer with pslverr) with programmable wait states sits on
// the APB side. Honours APB_MASTER_TIMEOUT_EN (TIMEOUT_CYCLES=4).
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  // Completer model controls
  int          wait_n    = 0;
  logic        stall_all = 1'b0;
  int          acc_cnt;
  logic [31:0] mem [0:31];

  apb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Completer: pready after wait_n ACCESS cycles unless stalled.
  always_comb begin
    pready = 1'b0;
    if (!stall_all && (acc_cnt >= wait_n)) pready = 1'b1;
    pslverr = (paddr >= 32'd32);
    prdata  = (paddr < 32'd32) ? mem[paddr[4:0]] : 32'h0;
  end

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (presetn && psel && penable && pready && pwrite && (paddr < 32'd32))
      mem[paddr[4:0]] <= pwdata;
  end

  // Single transfer, started at a negedge with the bridge idle.
  task automatic do_xfer(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input string name);
    int   n;
    logic seen;
    wait_n    = waits;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle got=%b exp=1", name, cmd_ready);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge pclk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if ({psel, penable, cmd_ready, pwrite} !== {1'b1, (n >= 2), 1'b0, wr}) begin
          failures++;
          $display("FAIL %s_ctrl cyc=%0d got psel/pen/rdy/pwr=%b%b%b%b exp=1%b0%b",
                   name, n, psel, penable, cmd_ready, pwrite, (n >= 2), wr);
        end
        checks++;
        if ({paddr, pwdata} !== {addr, wdata}) begin
          failures++;
          $display("FAIL %s_stable cyc=%0d got addr=%h data=%h exp addr=%h data=%h",
                   name, n, paddr, pwdata, addr, wdata);
        end
      end
    end
    checks++;
    if (!seen || n != 3 + waits) begin
      failures++;
      $display("FAIL %s_latency got=%0d seen=%b exp=%0d", name, n, seen, 3 + waits);
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== {exp_err, exp_rdata}) begin
      failures++;
      $display("FAIL %s_rsp got err=%b data=%h exp err=%b data=%h",
               name, rsp_err, rsp_rdata, exp_err, exp_rdata);
    end
    checks++;
    if ({psel, penable, cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL %s_idle got psel/pen/rdy=%b%b%b exp=001", name, psel, penable, cmd_ready);
    end
    @(negedge pclk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got rsp_valid=%b exp=0", name, rsp_valid);
    end
  endtask

  task automatic test_reset;
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    #12;
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl got psel/pen/pwr/rv/err=%b%b%b%b%b exp=00000",
               psel, penable, pwrite, rsp_valid, rsp_err);
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp=0", paddr, pwdata, rsp_rdata);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_write_read;
    do_xfer(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 32'h0, "wr5");
    do_xfer(1'b0, 32'd5, 32'h0, 0, 1'b0, 32'hDEADBEEF, "rd5");
  endtask

  task automatic test_error;
    do_xfer(1'b0, 32'd40, 32'h0, 0, 1'b1, 32'h0, "rd40_err");
    do_xfer(1'b1, 32'd40, 32'h1, 0, 1'b1, 32'h0, "wr40_err");
  endtask

  task automatic test_wait_states;
    // Three wait states: ACCESS lasts 4 cycles (also completes exactly at
    // the timeout limit when the timeout is built in).
    do_xfer(1'b1, 32'd7, 32'h12345678, 3, 1'b0, 32'h0, "wait3");
    do_xfer(1'b0, 32'd7, 32'h0, 1, 1'b0, 32'h12345678, "wait1_rd");
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [0:3];
    vals[0] = 32'hA0A0_0000;
    vals[1] = 32'hB1B1_1111;
    vals[2] = 32'hC2C2_2222;
    vals[3] = 32'hD3D3_3333;
    wait_n    = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'd0;
    cmd_wdata = vals[0];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cmd_ready, psel} !== 2'b10) begin
        failures++;
        $display("FAIL b2b_idle%0d got rdy/psel=%b%b exp=10", i, cmd_ready, psel);
      end
      @(negedge pclk);
      checks++;
      if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'(i)}) begin
        failures++;
        $display("FAIL b2b_setup%0d got psel/pen=%b%b addr=%h exp=10 addr=%h",
                 i, psel, penable, paddr, 32'(i));
      end
      if (i < 3) begin
        cmd_addr  = 32'(i + 1);
        cmd_wdata = vals[i+1];
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge pclk);
      checks++;
      if ({psel, penable} !== 2'b11) begin
        failures++;
        $display("FAIL b2b_access%0d got psel/pen=%b%b exp=11", i, psel, penable);
      end
      @(negedge pclk);
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10) begin
        failures++;
        $display("FAIL b2b_rsp%0d got rv/err=%b%b exp=10", i, rsp_valid, rsp_err);
      end
    end
    @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      do_xfer(1'b0, 32'(i), 32'h0, 0, 1'b0, vals[i], "b2b_rd");
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    stall_all = 1'b1;
    // 4 ACCESS cycles without pready -> abort, response 6 cycles after accept.
    do_xfer(1'b0, 32'd3, 32'h0, 3, 1'b1, 32'h0, "timeout");
    stall_all = 1'b0;
    do_xfer(1'b0, 32'd5, 32'h0, 0, 1'b0, 32'hDEADBEEF, "post_tmo_rd");
  endtask
`endif

  task automatic test_reset_mid_access;
    stall_all = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'd6;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
`ifndef APB_MASTER_TIMEOUT_EN
    repeat (100) @(negedge pclk);
`endif
    checks++;
    if ({psel, penable, cmd_ready} !== 3'b110) begin
      failures++;
      $display("FAIL stall_hold got psel/pen/rdy=%b%b%b exp=110", psel, penable, cmd_ready);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL async_rst got psel/pen/rv/rdy=%b%b%b%b exp=0001",
               psel, penable, rsp_valid, cmd_ready);
    end
    @(negedge pclk);
    presetn   = 1'b1;
    stall_all = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++;
      if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
        failures++;
        $display("FAIL post_rst%0d got rv/rdy/psel=%b%b%b exp=010", i, rsp_valid, cmd_ready, psel);
      end
    end
    do_xfer(1'b0, 32'd5, 32'h0, 0, 1'b0, 32'hDEADBEEF, "post_rst_rd");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_wait_states();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command interface into APB3 requester transfers: psel, penable, paddr, pwrite, pwdata.
- Returns read data and slave error on a single-cycle response strobe.
- Sits between an internal controller or testbench sequencer and APB completer blocks such as the team's 32-word APB RAM.
- Issues one transfer at a time, honours pready wait states and reports pslverr.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data paths.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort. Used only when APB_MASTER_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  transfer error (pslverr or timeout).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB completer ready.
- pslverr  in  1  APB completer error.

Behaviour:
- Reset (presetn low, asynchronous): state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0.
- Reset asserted mid-transfer drops psel/penable immediately. No response is generated for the aborted transfer.
- States:
  - IDLE: psel=0, penable=0; cmd_ready = 1 (combinational, state==IDLE). On cmd_valid&&cmd_ready, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0. Always exactly one cycle, then go to ACCESS.
  - ACCESS: psel=1, penable=1. Stay while pready=0 (wait states). On a rising edge with pready=1, go to IDLE and register the response.
- Response capture at the completing edge:
  - rsp_err = pslverr.
  - rsp_rdata = prdata for a read with pslverr=0; otherwise 0 (writes and errored reads).
  - rsp_valid = 1 for exactly the next cycle.
  - No backpressure on the response: the consumer must take it.
- paddr, pwrite, pwdata stay stable from SETUP through the end of ACCESS and hold their last values in IDLE. They change only on command acceptance.
- cmd_ready is 0 during SETUP and ACCESS. Commands presented then are not accepted and must be held by the source.
- Minimum latency: acceptance edge T0 -> SETUP cycle -> ACCESS cycle -> rsp_valid high in the cycle after edge T2. That is 3 cycles per zero-wait transfer; each wait state adds 1.
- Back-to-back: the cycle in which rsp_valid=1 is an IDLE cycle with cmd_ready=1, so the next command may be accepted in that same cycle.
- pslverr and prdata are sampled only when psel&&penable&&pready; they are ignored at all other times.
- No pipelining: one outstanding transfer maximum.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, go to IDLE: drop psel/penable; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 on the same edge the counter reaches TIMEOUT_CYCLES is a normal completion; normal completion wins.
- Not defined: no counter; ACCESS waits on pready indefinitely; rsp_err reflects pslverr only.

Test Plan:
- Write then read, zero wait: write addr 5, data 0xDEADBEEF to APB RAM -> psel rises one cycle before penable; rsp_valid after 3 cycles with rsp_err=0. Then read addr 5 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Error path: read addr 40 with completer asserting pslverr -> rsp_err=1, rsp_rdata=0. Then write addr 40, data 0x1 -> rsp_err=1.
- Wait states: completer holds pready=0 for 3 ACCESS cycles on a write to addr 7 -> ACCESS lasts 4 cycles; paddr=7 and pwdata stable throughout; cmd_ready=0 throughout; single rsp_valid pulse.
- Back-to-back: cmd_valid held high with 4 writes to addrs 0..3 -> each accepted in its rsp_valid cycle; psel deasserts for exactly 1 IDLE cycle between transfers; reads of 0..3 return written data.
- Reset mid-ACCESS: assert presetn=0 asynchronously while penable=1 -> psel/penable/rsp_valid go 0 without waiting for a clock edge; after release, cmd_ready=1 and no stale rsp_valid.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready tied 0 -> after 4 ACCESS cycles psel drops, rsp_valid=1 with rsp_err=1. Without the macro -> psel stays high after 100 cycles.
